color_speed_select: RTL

- Upstream stage of the rover motor PWM block; produces its 2-bit `speed` command.
- Drives the filter-select lines of the TCS3200-style colour sensor through red, blue, clear and green.
- For each filter, counts rising edges of the sensor frequency output over a fixed gate window.
- Classifies the dominant colour, debounces it across frames, and outputs a registered speed code.

---
 rtl/rover_pkg.sv | 45 ++++
 rtl/color_speed_select_if.sv | 29 ++
 rtl/freq_edge_counter.sv | 42 ++++
 rtl/color_speed_select.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rover_pkg.sv
// rtl/rover_pkg.sv - shared colour, speed and FSM types for the rover colour/speed path
//
// Purpose: types and constants shared by color_speed_select and its bench.
//   colour_t : raw classification code (NONE/RED/GREEN/BLUE)
//   SPD_*    : speed codes understood by the PWM stage
//   state_t  : measurement FSM states
//   CH_*     : filter channel index; {S2,S3} is the index itself
package rover_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      RED   = 2'b01,
      GREEN = 2'b10,
      BLUE  = 2'b11
   } colour_t;

   localparam logic [1:0] SPD_STOP   = 2'b00;
   localparam logic [1:0] SPD_LOW    = 2'b01;
   localparam logic [1:0] SPD_MID    = 2'b10;
   localparam logic [1:0] SPD_CRUISE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GATE,
      ST_NEXT,
      ST_CLASSIFY
   } state_t;

   // Channel order red, blue, clear, green; the index doubles as {S2,S3}.
   localparam logic [1:0] CH_RED   = 2'd0;
   localparam logic [1:0] CH_BLUE  = 2'd1;
   localparam logic [1:0] CH_CLEAR = 2'd2;
   localparam logic [1:0] CH_GREEN = 2'd3;

   function automatic logic [1:0] colour_to_speed(input colour_t c);
      case (c)
         RED:     return SPD_STOP;
         BLUE:    return SPD_LOW;
         GREEN:   return SPD_MID;
         default: return SPD_CRUISE;
      endcase
   endfunction

endpackage

// File: rtl/color_speed_select_if.sv
// rtl/color_speed_select_if.sv - sensor and speed-command signal bundle
//
// Purpose: groups the colour sensor and PWM-facing signals of color_speed_select.
//   enable      : run measurement frames while high
//   sensor_out  : asynchronous sensor frequency output
//   S2, S3      : sensor filter select
//   speed       : 2-bit speed code to the PWM stage
//   color_code  : last raw classification
//   frame_done  : one-cycle pulse per classified frame
// Modports: master = system/sensor side, slave = color_speed_select.
interface color_speed_select_if;
   logic       enable;
   logic       sensor_out;
   logic       S2;
   logic       S3;
   logic [1:0] speed;
   logic [1:0] color_code;
   logic       frame_done;

   modport master (
      output enable, sensor_out,
      input  S2, S3, speed, color_code, frame_done
   );

   modport slave (
      input  enable, sensor_out,
      output S2, S3, speed, color_code, frame_done
   );
endinterface

// File: rtl/freq_edge_counter.sv
// rtl/freq_edge_counter.sv - synchronised rising-edge counter for the sensor frequency output
//
// Purpose: 2-FF synchroniser, rising-edge detect and saturating counter.
//   clock, reset_n : clock, synchronous active-low reset
//   sensor_out     : asynchronous pulse train
//   clear          : zero the count (has priority over gate)
//   gate           : count detected edges while high
//   count          : edge count, saturates at all-ones
module freq_edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             sensor_out,
   input  logic             clear,
   input  logic             gate,
   output logic [CNT_W-1:0] count
);

   logic sync_1, sync_2, sync_prev;
   logic edge_det;

   assign edge_det = sync_2 & ~sync_prev;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
         count     <= '0;
      end else begin
         sync_1    <= sensor_out;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
         if (clear)
            count <= '0;
         else if (gate && edge_det && count != '1)
            count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/color_speed_select.sv
// rtl/color_speed_select.sv - colour-sensor frame sequencer, classifier and speed selector
//
// Purpose: cycles the sensor filters red, blue, clear, green; counts sensor edges
// per gate window, classifies the dominant colour and registers a speed code.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : enable, sensor_out in; S2, S3, speed, color_code, frame_done out
// Build option: define COLOR_CONFIRM_EN to require CONFIRM identical consecutive
// classifications before speed changes; otherwise speed follows every frame.
module color_speed_select
   import rover_pkg::*;
#(
   parameter int GATE_CYCLES   = 100000,
   parameter int SETTLE_CYCLES = 1000,
   parameter int CNT_W         = 16,
`ifdef COLOR_CONFIRM_EN
   parameter int CONFIRM       = 3,
`endif
   parameter int MIN_CLEAR     = 200
) (
   input logic                 clock,
   input logic                 reset_n,
   color_speed_select_if.slave bus
);

   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t           state, next_state;
   logic [TMR_W-1:0] timer;
   logic [1:0]       ch;
   logic [CNT_W-1:0] count, cnt_red, cnt_blue, cnt_clear, cnt_green;
   logic [1:0]       speed_q;
   colour_t          colour_q, cls;
   logic             done_q, confirmed;
   logic             win_clear, win_gate, store, classify, abort;

   freq_edge_counter #(.CNT_W(CNT_W)) u_counter (
      .clock      (clock),
      .reset_n    (reset_n),
      .sensor_out (bus.sensor_out),
      .clear      (win_clear),
      .gate       (win_gate),
      .count      (count)
   );

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Next-state logic; losing enable anywhere outside IDLE abandons the frame
   always_comb begin
      next_state = state;
      if (state != ST_IDLE && !bus.enable) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (bus.enable) next_state = ST_SETTLE;
            ST_SETTLE:   if (timer == TMR_W'(SETTLE_CYCLES - 1)) next_state = ST_GATE;
            ST_GATE:     if (timer == TMR_W'(GATE_CYCLES - 1)) next_state = ST_NEXT;
            ST_NEXT:     next_state = (ch == CH_GREEN) ? ST_CLASSIFY : ST_SETTLE;
            ST_CLASSIFY: next_state = ST_SETTLE;
            default:     next_state = ST_IDLE;
         endcase
      end
   end

   // Control strobes
   always_comb begin
      win_clear = 1'b0;
      win_gate  = 1'b0;
      store     = 1'b0;
      classify  = 1'b0;
      abort     = (state != ST_IDLE) && !bus.enable;
      case (state)
         ST_IDLE, ST_SETTLE: win_clear = 1'b1;
         ST_GATE:            win_gate  = 1'b1;
         ST_NEXT:            store     = !abort;
         ST_CLASSIFY:        classify  = 1'b1;
         default:            ;
      endcase
   end

   // Phase timer restarts on every state change
   always_ff @(posedge clock) begin
      if (!reset_n)
         timer <= '0;
      else if (next_state != state || state == ST_IDLE)
         timer <= '0;
      else
         timer <= timer + TMR_W'(1);
   end

   // Channel index and per-channel count capture
   always_ff @(posedge clock) begin
      if (!reset_n || abort) begin
         ch        <= CH_RED;
         cnt_red   <= '0;
         cnt_blue  <= '0;
         cnt_clear <= '0;
         cnt_green <= '0;
      end else if (store) begin
         case (ch)
            CH_RED:   cnt_red   <= count;
            CH_BLUE:  cnt_blue  <= count;
            CH_CLEAR: cnt_clear <= count;
            default:  cnt_green <= count;
         endcase
         // Green stays selected through CLASSIFY; the frame restarts at red after it
         if (ch != CH_GREEN) ch <= ch + 2'd1;
      end else if (classify) begin
         ch <= CH_RED;
      end
   end

   // A colour wins only when strictly above both other colours and clear is bright enough
   always_comb begin
      cls = NONE;
      if (32'(cnt_clear) >= 32'(MIN_CLEAR)) begin
         if (cnt_red > cnt_blue && cnt_red > cnt_green)
            cls = RED;
         else if (cnt_green > cnt_red && cnt_green > cnt_blue)
            cls = GREEN;
         else if (cnt_blue > cnt_red && cnt_blue > cnt_green)
            cls = BLUE;
      end
   end

`ifdef COLOR_CONFIRM_EN
   localparam int CONF_W = $clog2(CONFIRM + 1);

   colour_t           cand;
   logic [CONF_W-1:0] conf_cnt, conf_next;

   // Run length of identical classifications, saturating at CONFIRM
   always_comb begin
      if (cls != cand)
         conf_next = CONF_W'(1);
      else if (conf_cnt != CONF_W'(CONFIRM))
         conf_next = conf_cnt + CONF_W'(1);
      else
         conf_next = conf_cnt;
   end

   assign confirmed = (conf_next >= CONF_W'(CONFIRM));

   always_ff @(posedge clock) begin
      if (!reset_n || abort) begin
         cand     <= NONE;
         conf_cnt <= '0;
      end else if (classify) begin
         cand     <= cls;
         conf_cnt <= conf_next;
      end
   end
`else
   assign confirmed = 1'b1;
`endif

   // Registered outputs; an abort forces stop even on the CLASSIFY cycle
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         speed_q  <= SPD_STOP;
         colour_q <= NONE;
         done_q   <= 1'b0;
      end else begin
         done_q <= classify;
         if (classify) colour_q <= cls;
         if (abort)
            speed_q <= SPD_STOP;
         else if (classify && confirmed)
            speed_q <= colour_to_speed(cls);
      end
   end

   assign bus.S2         = ch[1];
   assign bus.S3         = ch[0];
   assign bus.speed      = speed_q;
   assign bus.color_code = colour_q;
   assign bus.frame_done = done_q;

endmodule
